mem_fill_ctrl: RTL and testbench

Writer-side controller for the 1024-byte data memory that the max/min search FSM scans.
- Accepts a byte stream over a valid/ready handshake and writes bytes to addresses 0..DEPTH-1 in order.
- Once the last byte is committed, pulses scan_start to the search FSM, waits for its scan_done, then reports completion.
- Sits between the stream source and the memory write port; the search FSM owns the read port.

---
 rtl/mem_fill_pkg.sv | 18 +
 rtl/mem_wr_port_reg.sv | 43 ++++
 rtl/mem_fill_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_fill_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg: shared types and default sizing for the memory fill controller.
//   fill_state_t : controller FSM states
//   DEPTH/AW/DW  : default memory depth, address width and data width
package mem_fill_pkg;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    KICK,
    WAIT
  } fill_state_t;

endpackage

// File: rtl/mem_wr_port_reg.sv
// mem_wr_port_reg: registered memory write stage plus the running write counter.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   clear                 : zero the write counter
//   wr_en, wr_data        : accept one byte this cycle
//   mem_we/mem_addr/mem_wdata : registered write port, valid the cycle after wr_en
//   wr_count              : bytes written so far (AW+1 bits so DEPTH fits)
module mem_wr_port_reg #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW:0]   wr_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_count  <= '0;
    end else begin
      mem_we <= wr_en;
      if (clear) begin
        wr_count <= '0;
      end else if (wr_en) begin
        // Address is the pre-increment count; the counter itself may reach
        // DEPTH, but the address never wraps because FILL exits at DEPTH-1.
        mem_addr  <= wr_count[AW-1:0];
        mem_wdata <= wr_data;
        wr_count  <= wr_count + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: writer-side controller that fills the data memory from a
// valid/ready byte stream, then kicks the search FSM and waits for it.
// Optional: define FILL_CHECKSUM_EN to add the checksum output (mod 2**DW sum
// of accepted bytes).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   fill_start, abort    : begin a fill (IDLE only) / cancel a fill (FILL only)
//   in_valid/in_data/in_ready : input byte stream handshake
//   mem_we/mem_addr/mem_wdata : registered memory write port
//   scan_start/scan_done : start pulse to / completion from the search FSM
//   busy, fill_done      : not-IDLE flag, one-cycle completion pulse
//   wr_count             : bytes written so far, 0..DEPTH
module mem_fill_ctrl #(
  parameter int DEPTH = mem_fill_pkg::DEPTH,
  parameter int AW    = mem_fill_pkg::AW,
  parameter int DW    = mem_fill_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          scan_start,
  input  logic          scan_done,
  output logic          busy,
  output logic          fill_done,
  output logic [AW:0]   wr_count
`ifdef FILL_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  import mem_fill_pkg::*;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  fill_state_t state, state_nxt;
  logic        hs;
  logic        clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_done <= (state == WAIT) && scan_done;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    scan_start = 1'b0;
    clear      = 1'b0;
    hs         = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (fill_start) begin
          clear     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        // abort suppresses a simultaneous handshake: the byte is dropped
        if (abort) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end else if (in_valid) begin
          hs = 1'b1;
          if (wr_count == LAST_IDX) state_nxt = FLUSH;
        end
      end
      FLUSH: state_nxt = KICK;
      KICK: begin
        scan_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (scan_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mem_wr_port_reg #(
    .AW (AW),
    .DW (DW)
  ) u_wr_port (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .wr_en     (hs),
    .wr_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wr_count  (wr_count)
  );

`ifdef FILL_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && fill_start) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_fill_ctrl.sv
module tb_mem_fill_ctrl;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst, fill_start, abort, in_valid, scan_done;
  logic [DW-1:0] in_data;
  logic          in_ready, mem_we, scan_start, busy, fill_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   wr_count;
`ifdef FILL_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_fill_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .scan_start (scan_start),
    .scan_done  (scan_done),
    .busy       (busy),
    .fill_done  (fill_done),
    .wr_count   (wr_count)
`ifdef FILL_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  wr_t         wr_q[$];
  logic [7:0]  exp_q[$];
  int          scan_pulses = 0;
  int          done_pulses = 0;
  int          model_sum   = 0;

  // Observe the write port and pulses shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (mem_we === 1'b1) wr_q.push_back('{a: mem_addr, d: mem_wdata});
    if (scan_start === 1'b1) scan_pulses++;
    if (fill_done === 1'b1) done_pulses++;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int mode, input int idx);
    case (mode)
      0: gen = 8'(idx);
      1: gen = 8'($urandom);
      2: gen = 8'hFF;
      default: gen = (idx == 0) ? 8'd1 : (idx == 1) ? 8'd2 : 8'd0;
    endcase
  endfunction

  task automatic start_fill;
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_wr_count", 32'(wr_count), 0);
    exp_q.delete();
    wr_q.delete();
    model_sum = 0;
  endtask

  // Drives bytes until DEPTH are accepted, or aborts on byte stop_at.
  task automatic feed(input int mode, input bit gaps, input int stop_at, output bit aborted);
    int acc = 0;
    int guard = 0;
    logic v;
    logic [7:0] d;
    aborted = 1'b0;
    while (acc < DEPTH) begin
      if (guard++ > 20 * DEPTH) begin
        n_fail++;
        $error("FAIL feed_timeout: observed %0d accepted expected %0d", acc, DEPTH);
        break;
      end
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = gen(mode, acc);
      in_valid = v;
      in_data  = d;
      if (v && acc == stop_at) abort = 1'b1;
      if (acc % 64 == 0) chk("fill_in_ready", 32'(in_ready), 1);
      tick;
      if (abort) begin
        abort    = 1'b0;
        in_valid = 1'b0;
        aborted  = 1'b1;
        return;
      end
      if (v) begin
        exp_q.push_back(d);
        model_sum = (model_sum + int'(d)) % 256;
        acc++;
      end
    end
    in_valid = 1'b0;
  endtask

  // Called on the FLUSH cycle right after the last handshake; checks the
  // tail of the fill, the kick pulse timing and the whole write sequence.
  task automatic check_tail(input int scan_before);
    int errs = 0;
    chk("flush_mem_we", 32'(mem_we), 1);
    chk("flush_mem_addr", 32'(mem_addr), DEPTH - 1);
    chk("flush_wr_count", 32'(wr_count), DEPTH);
    chk("flush_in_ready", 32'(in_ready), 0);
    chk("flush_scan_start", 32'(scan_start), 0);
`ifdef FILL_CHECKSUM_EN
    chk("checksum", 32'(checksum), model_sum);
`endif
    tick;
    chk("kick_scan_start", 32'(scan_start), 1);
    chk("kick_mem_we", 32'(mem_we), 0);
    tick;
    chk("wait_scan_start", 32'(scan_start), 0);
    chk("wait_busy", 32'(busy), 1);
    chk("scan_pulse_count", scan_pulses, scan_before + 1);
    chk("write_count", wr_q.size(), DEPTH);
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i].a !== AW'(i) || wr_q[i].d !== exp_q[i]) errs++;
    chk("write_sequence_errors", errs, 0);
  endtask

  task automatic finish_scan;
    int done_before = done_pulses;
    scan_done = 1'b1;
    tick;
    scan_done = 1'b0;
    chk("fill_done_pulse", 32'(fill_done), 1);
    chk("done_busy", 32'(busy), 0);
    tick;
    tick;
    chk("fill_done_low", 32'(fill_done), 0);
    chk("fill_done_once", done_pulses, done_before + 1);
  endtask

  initial begin
    bit ab;
    int sb;
    rst = 1'b1; fill_start = 1'b0; abort = 1'b0; scan_done = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA;

    // Reset with stream activity
    tick;
    tick;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_scan_start", 32'(scan_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    rst = 1'b0; in_valid = 1'b0;
    scan_done = 1'b1;
    tick;
    scan_done = 1'b0;
    chk("idle_ignores_scan_done", 32'(busy), 0);
    chk("idle_no_fill_done", 32'(fill_done), 0);

    // Back-to-back fill with data = address
    sb = scan_pulses;
    start_fill;
    feed(0, 1'b0, -1, ab);
    check_tail(sb);
    finish_scan;

    // Random gaps, random data
    sb = scan_pulses;
    start_fill;
    feed(1, 1'b1, -1, ab);
    check_tail(sb);
    finish_scan;

    // Abort colliding with the handshake of byte 300
    sb = scan_pulses;
    start_fill;
    feed(1, 1'b0, 300, ab);
    chk("abort_taken", 32'(ab), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wr_count", 32'(wr_count), 0);
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    chk("abort_writes", wr_q.size(), 300);
    tick;
    chk("abort_no_scan", scan_pulses, sb);

    // Restart after abort, begins at address 0
    start_fill;
    feed(1, 1'b1, -1, ab);
    check_tail(sb);

    // fill_start and abort ignored in WAIT; long scan
    fill_start = 1'b1; abort = 1'b1;
    tick;
    fill_start = 1'b0; abort = 1'b0;
    chk("wait_ignores_start_abort", 32'(busy), 1);
    chk("wait_wr_count_held", 32'(wr_count), DEPTH);
    repeat (5000) tick;
    chk("wait_long_busy", 32'(busy), 1);
    chk("wait_no_extra_writes", wr_q.size(), DEPTH);
    chk("wait_single_scan", scan_pulses, sb + 1);
    finish_scan;

`ifdef FILL_CHECKSUM_EN
    sb = scan_pulses;
    start_fill;
    feed(2, 1'b0, -1, ab);
    check_tail(sb);
    chk("checksum_ff", 32'(checksum), 0);
    finish_scan;
    chk("checksum_held", 32'(checksum), 0);
    sb = scan_pulses;
    start_fill;
    feed(3, 1'b1, -1, ab);
    check_tail(sb);
    chk("checksum_3", 32'(checksum), 3);
    finish_scan;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
